cla_carry_pipe: RTL and testbench

CLA_CARRY_PIPE -- requirements
Module: cla_carry_pipe

---
 rtl/cla_carry_pipe.sv | 103 ++++++++++
 tb/tb_cla_carry_pipe.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cla_carry_pipe.sv
// Two-stage pipelined 5-bit carry-lookahead block with valid/ready handshakes.
// S1 registers the g_bar/p/cin triple; S2 registers sum, cout and the group terms.
module cla_carry_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] g_bar,
  input  logic [4:0] p,
  input  logic       cin,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] sum,
  output logic       cout,
  output logic       grp_g_bar,
  output logic       grp_p
);

  logic       s1_v;
  logic [4:0] s1_g_bar;
  logic [4:0] s1_p;
  logic       s1_cin;

  logic       s2_v;
  logic [4:0] s2_sum;
  logic       s2_cout;
  logic       s2_grp_g;
  logic       s2_grp_p;

  logic       advance;
  logic       s1_load;
  logic [4:0] g;
  logic [5:0] c;
  logic       grp_g;

  assign advance  = ~s2_v | out_ready;
  assign in_ready = ~s1_v | ~s2_v | out_ready;
  // An empty S1 also loads while S2 stalls, so every in_ready=1 handshake is captured.
  assign s1_load  = advance | ~s1_v;

  // Two-level lookahead: each carry is a flat sum of products of g, p and cin.
  always_comb begin
    g    = ~s1_g_bar;
    c    = '0;
    c[0] = s1_cin;
    c[1] = g[0] | (s1_p[0] & s1_cin);
    c[2] = g[1] | (s1_p[1] & g[0]) | (s1_p[1] & s1_p[0] & s1_cin);
    c[3] = g[2] | (s1_p[2] & g[1]) | (s1_p[2] & s1_p[1] & g[0])
         | (s1_p[2] & s1_p[1] & s1_p[0] & s1_cin);
    c[4] = g[3] | (s1_p[3] & g[2]) | (s1_p[3] & s1_p[2] & g[1])
         | (s1_p[3] & s1_p[2] & s1_p[1] & g[0])
         | (s1_p[3] & s1_p[2] & s1_p[1] & s1_p[0] & s1_cin);
    c[5] = g[4] | (s1_p[4] & g[3]) | (s1_p[4] & s1_p[3] & g[2])
         | (s1_p[4] & s1_p[3] & s1_p[2] & g[1])
         | (s1_p[4] & s1_p[3] & s1_p[2] & s1_p[1] & g[0])
         | (s1_p[4] & s1_p[3] & s1_p[2] & s1_p[1] & s1_p[0] & s1_cin);
    grp_g = g[4] | (s1_p[4] & g[3]) | (s1_p[4] & s1_p[3] & g[2])
          | (s1_p[4] & s1_p[3] & s1_p[2] & g[1])
          | (s1_p[4] & s1_p[3] & s1_p[2] & s1_p[1] & g[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s1_g_bar <= '0;
      s1_p     <= '0;
      s1_cin   <= 1'b0;
    end else if (s1_load) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_g_bar <= g_bar;
        s1_p     <= p;
        s1_cin   <= cin;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v     <= 1'b0;
      s2_sum   <= '0;
      s2_cout  <= 1'b0;
      s2_grp_g <= 1'b0;
      s2_grp_p <= 1'b0;
    end else if (advance) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_sum   <= s1_p ^ c[4:0];
        s2_cout  <= c[5];
        s2_grp_g <= grp_g;
        s2_grp_p <= &s1_p;
      end
    end
  end

  // Group generate is stored true-polarity so a cleared register reads grp_g_bar=1.
  assign out_valid = s2_v;
  assign sum       = s2_sum;
  assign cout      = s2_cout;
  assign grp_g_bar = ~s2_grp_g;
  assign grp_p     = s2_grp_p;

endmodule

// File: tb/tb_cla_carry_pipe.sv
// Directed and exhaustive self-checking bench for cla_carry_pipe.
module tb_cla_carry_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] g_bar;
  logic [4:0] p;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] sum;
  logic       cout;
  logic       grp_g_bar;
  logic       grp_p;

  int checks = 0;
  int errors = 0;

  cla_carry_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .g_bar     (g_bar),
    .p         (p),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .grp_g_bar (grp_g_bar),
    .grp_p     (grp_p)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put(input logic [4:0] a, input logic [4:0] b, input logic c);
    g_bar    = ~(a & b);
    p        = a ^ b;
    cin      = c;
    in_valid = 1'b1;
  endtask

  // {out_valid, cout, grp_g_bar, grp_p, sum}
  function automatic logic [8:0] obs();
    return {out_valid, cout, grp_g_bar, grp_p, sum};
  endfunction

  initial begin
    int          sent;
    int          done;
    int          ncyc;
    int          stale;
    logic [10:0] q[$];
    logic [10:0] e;
    logic [5:0]  tot;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    g_bar     = '1;
    p         = '0;
    cin       = 1'b0;
    @(negedge clk);
    cyc();
    rst = 1'b0;
    #1;
    check("rst_out", obs(), 9'b0_0_1_0_00000);
    check("rst_in_ready", in_ready, 1);

    // Three directed vectors back to back with out_ready=1.
    put(5'd22, 5'd11, 1'b0);
    cyc();
    put(5'd31, 5'd0, 1'b1);
    cyc();
    check("dir_22_11", obs(), 9'b1_1_0_0_00001);
    g_bar = 5'b11111; p = 5'b00000; cin = 1'b0;
    cyc();
    check("dir_31_0_c1", obs(), 9'b1_1_1_1_00000);
    in_valid = 1'b0;
    cyc();
    check("dir_zero", obs(), 9'b1_0_1_0_00000);
    cyc();
    check("dir_drained", out_valid, 0);

    // Backpressure: out_ready low, offer A, B, C back to back.
    out_ready = 1'b0;
    put(5'd3, 5'd5, 1'b0);
    #1 check("bp_rdy1", in_ready, 1);
    cyc();
    put(5'd20, 5'd15, 1'b1);
    #1 check("bp_rdy2", in_ready, 1);
    cyc();
    put(5'd9, 5'd22, 1'b0);
    #1 check("bp_rdy3", in_ready, 0);
    check("bp_hold_a0", obs(), 9'b1_0_1_0_01000);
    cyc();
    check("bp_rdy4", in_ready, 0);
    check("bp_hold_a1", obs(), 9'b1_0_1_0_01000);
    cyc();
    check("bp_hold_a2", obs(), 9'b1_0_1_0_01000);
    out_ready = 1'b1;
    #1 check("bp_rdy_release", in_ready, 1);
    cyc();
    check("bp_out_b", obs(), 9'b1_1_0_0_00100);
    in_valid = 1'b0;
    cyc();
    check("bp_out_c", obs(), 9'b1_0_1_1_11111);
    cyc();
    check("bp_empty", out_valid, 0);

    // Reset with both stages full; nothing from before may emerge.
    out_ready = 1'b0;
    put(5'd1, 5'd1, 1'b0);
    cyc();
    put(5'd2, 5'd2, 1'b0);
    cyc();
    check("mr_full", out_valid, 1);
    in_valid = 1'b0;
    rst      = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("mr_out_valid", out_valid, 0);
    check("mr_in_ready", in_ready, 1);
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (out_valid) stale++;
    end
    check("mr_no_stale", stale, 0);

    // Exhaustive stream of all (a, b, cin) with random stalls on both sides.
    sent = 0;
    done = 0;
    ncyc = 0;
    while ((sent < 2048 || done < 2048) && ncyc < 20000) begin
      @(negedge clk);
      ncyc++;
      if (sent < 2048) begin
        e = sent[10:0];
        put(e[10:6], e[5:1], e[0]);
        in_valid = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = $urandom_range(0, 1);
      #4;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("exh_extra", 1, 0);
        end else begin
          e   = q.pop_front();
          tot = {1'b0, e[10:6]} + {1'b0, e[5:1]} + {5'd0, e[0]};
          check("exh_result", {cout, sum, grp_g_bar, grp_p},
                {tot, ({1'b0, e[10:6]} + {1'b0, e[5:1]}) < 6'd32, &(e[10:6] ^ e[5:1])});
          done++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(sent[10:0]);
        sent++;
      end
    end
    check("exh_done", done, 2048);
    check("exh_queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
